// File: rtl/pll_ctrl.sv
// PLL configuration and lock sequencer: loads dividers, sequences PLL reset, waits for lock, watches for loss of lock.
// Optional automatic lock retry on timeout is enabled by defining PLL_CTRL_AUTO_RETRY_EN.
module pll_ctrl #(
   parameter int REF_DIV_WIDTH = 4,
   parameter int FB_DIV_WIDTH  = 8,
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int LOL_FILTER    = 4,
   parameter int MAX_RETRY     = 3
) (
   input  logic                     clk_i,
   input  logic                     srst_i,
   input  logic                     cfg_valid_i,
   output logic                     cfg_ready_o,
   input  logic [REF_DIV_WIDTH-1:0] cfg_ref_div_i,
   input  logic [FB_DIV_WIDTH-1:0]  cfg_fb_div_i,
   output logic                     cfg_err_o,
   output logic                     pll_arst_no,
   output logic [REF_DIV_WIDTH-1:0] pll_ref_div_o,
   output logic [FB_DIV_WIDTH-1:0]  pll_fb_div_o,
   input  logic                     pll_locked_i,
   output logic                     ready_o,
   output logic                     busy_o,
   output logic                     fault_o,
   output logic                     lock_lost_o
);

   if (RST_CYCLES < 1 || LOCK_TIMEOUT < 2 || LOL_FILTER < 1 || MAX_RETRY < 0) begin : g_param_check
      $error("pll_ctrl: illegal parameter value");
   end

   // One counter serves the reset hold, the lock timer and the loss-of-lock filter.
   localparam int CNT_MAX = (LOCK_TIMEOUT > RST_CYCLES)
                          ? ((LOCK_TIMEOUT > LOL_FILTER) ? LOCK_TIMEOUT : LOL_FILTER)
                          : ((RST_CYCLES > LOL_FILTER) ? RST_CYCLES : LOL_FILTER);
   localparam int CNT_W   = $clog2(CNT_MAX);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_WAIT_LOCK,
      ST_LOCKED,
      ST_FAULT
   } state_t;

   state_t                   state_reg, state_next;
   logic [CNT_W-1:0]         cnt_reg, cnt_next;
   logic [REF_DIV_WIDTH-1:0] ref_div_reg, ref_div_next;
   logic [FB_DIV_WIDTH-1:0]  fb_div_reg, fb_div_next;
   logic                     cfg_err_reg, cfg_err_next;
   logic                     lock_lost_reg, lock_lost_next;
   logic [1:0]               sync_reg;
   logic                     locked_sync;
   logic                     accept;
   logic                     cfg_bad;

`ifdef PLL_CTRL_AUTO_RETRY_EN
   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RETRY_W-1:0] retry_reg, retry_next;
`endif

   assign locked_sync = sync_reg[1];
   assign cfg_ready_o = ~srst_i & ((state_reg == ST_IDLE) | (state_reg == ST_LOCKED) |
                                   (state_reg == ST_FAULT));
   assign accept      = cfg_valid_i & cfg_ready_o;
   assign cfg_bad     = (cfg_ref_div_i == '0) | (cfg_fb_div_i == '0);

   assign pll_arst_no   = (state_reg == ST_WAIT_LOCK) | (state_reg == ST_LOCKED);
   assign ready_o       = (state_reg == ST_LOCKED);
   assign busy_o        = (state_reg == ST_RESET) | (state_reg == ST_WAIT_LOCK);
   assign fault_o       = (state_reg == ST_FAULT);
   assign pll_ref_div_o = ref_div_reg;
   assign pll_fb_div_o  = fb_div_reg;
   assign cfg_err_o     = cfg_err_reg;
   assign lock_lost_o   = lock_lost_reg;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         ref_div_reg   <= '0;
         fb_div_reg    <= '0;
         cfg_err_reg   <= 1'b0;
         lock_lost_reg <= 1'b0;
         sync_reg      <= '0;
`ifdef PLL_CTRL_AUTO_RETRY_EN
         retry_reg     <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         ref_div_reg   <= ref_div_next;
         fb_div_reg    <= fb_div_next;
         cfg_err_reg   <= cfg_err_next;
         lock_lost_reg <= lock_lost_next;
         sync_reg      <= {sync_reg[0], pll_locked_i};
`ifdef PLL_CTRL_AUTO_RETRY_EN
         retry_reg     <= retry_next;
`endif
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      ref_div_next   = ref_div_reg;
      fb_div_next    = fb_div_reg;
      cfg_err_next   = 1'b0;
      lock_lost_next = 1'b0;
`ifdef PLL_CTRL_AUTO_RETRY_EN
      retry_next     = retry_reg;
`endif

      case (state_reg)
         ST_RESET: begin
            if (cnt_reg == CNT_W'(RST_CYCLES - 1)) begin
               state_next = ST_WAIT_LOCK;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            // Lock is checked first so it wins over a coincident timeout.
            if (locked_sync) begin
               state_next = ST_LOCKED;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
               cnt_next = '0;
`ifdef PLL_CTRL_AUTO_RETRY_EN
               if (retry_reg < RETRY_W'(MAX_RETRY)) begin
                  retry_next = retry_reg + RETRY_W'(1);
                  state_next = ST_RESET;
               end else begin
                  state_next = ST_FAULT;
               end
`else
               state_next = ST_FAULT;
`endif
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         ST_LOCKED: begin
            if (locked_sync) begin
               cnt_next = '0;
            end else if (cnt_reg == CNT_W'(LOL_FILTER - 1)) begin
               state_next     = ST_RESET;
               cnt_next       = '0;
               lock_lost_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: ;
      endcase

      // A good config overrides whatever the state machine decided this cycle.
      if (accept) begin
         if (cfg_bad) begin
            cfg_err_next = 1'b1;
         end else begin
            state_next     = ST_RESET;
            cnt_next       = '0;
            ref_div_next   = cfg_ref_div_i;
            fb_div_next    = cfg_fb_div_i;
            lock_lost_next = 1'b0;
`ifdef PLL_CTRL_AUTO_RETRY_EN
            retry_next     = '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed-plus-random bench for pll_ctrl: expected timings are derived from the cycle rules
// (reset hold length, synchroniser latency, lock timeout, loss-of-lock filter) with plain arithmetic.
module tb_pll_ctrl;

   localparam int REF_W      = 4;
   localparam int FB_W       = 8;
   localparam int RST_CYC    = 16;
   localparam int TIMEOUT    = 64;
   localparam int LOL        = 4;
   localparam int RETRIES    = 3;
`ifdef PLL_CTRL_AUTO_RETRY_EN
   localparam int ATTEMPTS   = 1 + RETRIES;
`else
   localparam int ATTEMPTS   = 1;
`endif
   // Latest point (cycles after pll_arst_no rises) at which raising lock still beats the timeout.
   localparam int LAST_LOCK  = TIMEOUT - 3;

   logic             clk_i = 1'b0;
   logic             srst_i;
   logic             cfg_valid_i;
   logic             cfg_ready_o;
   logic [REF_W-1:0] cfg_ref_div_i;
   logic [FB_W-1:0]  cfg_fb_div_i;
   logic             cfg_err_o;
   logic             pll_arst_no;
   logic [REF_W-1:0] pll_ref_div_o;
   logic [FB_W-1:0]  pll_fb_div_o;
   logic             pll_locked_i;
   logic             ready_o;
   logic             busy_o;
   logic             fault_o;
   logic             lock_lost_o;

   int n_checks = 0;
   int n_errors = 0;

   logic [REF_W-1:0] cur_ref;
   logic [FB_W-1:0]  cur_fb;

   pll_ctrl #(
      .REF_DIV_WIDTH(REF_W),
      .FB_DIV_WIDTH (FB_W),
      .RST_CYCLES   (RST_CYC),
      .LOCK_TIMEOUT (TIMEOUT),
      .LOL_FILTER   (LOL),
      .MAX_RETRY    (RETRIES)
   ) dut (
      .clk_i        (clk_i),
      .srst_i       (srst_i),
      .cfg_valid_i  (cfg_valid_i),
      .cfg_ready_o  (cfg_ready_o),
      .cfg_ref_div_i(cfg_ref_div_i),
      .cfg_fb_div_i (cfg_fb_div_i),
      .cfg_err_o    (cfg_err_o),
      .pll_arst_no  (pll_arst_no),
      .pll_ref_div_o(pll_ref_div_o),
      .pll_fb_div_o (pll_fb_div_o),
      .pll_locked_i (pll_locked_i),
      .ready_o      (ready_o),
      .busy_o       (busy_o),
      .fault_o      (fault_o),
      .lock_lost_o  (lock_lost_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(negedge clk_i);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Offer a good config at the current sample point; afterwards sits one edge later.
   task automatic accept_cfg(input string tag, input logic [REF_W-1:0] r, input logic [FB_W-1:0] f);
      chk({tag, "_cfg_ready"}, cfg_ready_o, 1);
      cfg_valid_i = 1'b1; cfg_ref_div_i = r; cfg_fb_div_i = f;
      step();
      cfg_valid_i = 1'b0;
      cur_ref = r; cur_fb = f;
      chk({tag, "_ref_div"}, pll_ref_div_o, r);
      chk({tag, "_fb_div"},  pll_fb_div_o, f);
      chk({tag, "_arst_low"}, pll_arst_no, 0);
      chk({tag, "_ready_clr"}, ready_o, 0);
      chk({tag, "_fault_clr"}, fault_o, 0);
      chk({tag, "_cfg_busy"}, cfg_ready_o, 0);
      $display("cfg  %s ref=%0d fb=%0d", tag, r, f);
   endtask

   // Count low samples of pll_arst_no from the current sample; the PLL model drops lock while in reset.
   task automatic measure_reset(input string tag, input int exp_pulses);
      int low = 0;
      int pulses = 0;
      pll_locked_i = 1'b0;
      chk({tag, "_busy_reset"}, busy_o, 1);
      while (pll_arst_no !== 1'b1 && low < 1000) begin
         if (lock_lost_o === 1'b1) pulses++;
         low++;
         step();
      end
      chk({tag, "_arst_low_cycles"}, low, RST_CYC);
      chk({tag, "_lock_lost_pulses"}, pulses, exp_pulses);
      chk({tag, "_busy_wait"}, busy_o, 1);
      $display("rst  %s low=%0d", tag, low);
   endtask

   // Raise lock d cycles after pll_arst_no rose; ready follows three edges later.
   task automatic lock_after(input string tag, input int d);
      repeat (d) step();
      pll_locked_i = 1'b1;
      step(); step();
      chk({tag, "_ready_early"}, ready_o, 0);
      step();
      chk({tag, "_ready"}, ready_o, 1);
      chk({tag, "_busy_locked"}, busy_o, 0);
      chk({tag, "_arst_high"}, pll_arst_no, 1);
      $display("lock %s delay=%0d", tag, d);
   endtask

   task automatic wait_timeout(input string tag);
      int high = 0;
      while (pll_arst_no === 1'b1 && high < 1000) begin
         high++;
         step();
      end
      chk({tag, "_wait_cycles"}, high, TIMEOUT);
      $display("tout %s wait=%0d", tag, high);
   endtask

   task automatic offer_bad(input string tag, input logic [REF_W-1:0] r, input logic [FB_W-1:0] f,
                            input logic exp_ready, input logic exp_fault);
      logic exp_arst;
      exp_arst = pll_arst_no;
      cfg_valid_i = 1'b1; cfg_ref_div_i = r; cfg_fb_div_i = f;
      step();
      cfg_valid_i = 1'b0;
      chk({tag, "_err_pulse"}, cfg_err_o, 1);
      chk({tag, "_ref_kept"}, pll_ref_div_o, cur_ref);
      chk({tag, "_fb_kept"},  pll_fb_div_o, cur_fb);
      chk({tag, "_arst_kept"}, pll_arst_no, exp_arst);
      chk({tag, "_ready_kept"}, ready_o, exp_ready);
      chk({tag, "_fault_kept"}, fault_o, exp_fault);
      step();
      chk({tag, "_err_clear"}, cfg_err_o, 0);
      $display("bad  %s ref=%0d fb=%0d", tag, r, f);
   endtask

   initial begin
      int bad;
      srst_i = 1'b1; cfg_valid_i = 1'b0; cfg_ref_div_i = '0; cfg_fb_div_i = '0; pll_locked_i = 1'b0;
      cur_ref = '0; cur_fb = '0;

      // Reset values
      repeat (3) step();
      chk("rst_arst", pll_arst_no, 0);
      chk("rst_ref", pll_ref_div_o, 0);
      chk("rst_fb", pll_fb_div_o, 0);
      chk("rst_ready", ready_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_fault", fault_o, 0);
      chk("rst_lost", lock_lost_o, 0);
      chk("rst_err", cfg_err_o, 0);
      chk("rst_cfg_ready", cfg_ready_o, 0);
      srst_i = 1'b0;
      #1;
      chk("rel_cfg_ready", cfg_ready_o, 1);
      $display("reset released");

      // Basic configure and lock
      step();
      accept_cfg("t2", 4'd2, 8'd40);
      measure_reset("t2", 0);
      lock_after("t2", $urandom_range(0, 50));

      // Rejected configs while locked
      offer_bad("t3_fb0", 4'($urandom_range(1, 15)), 8'd0, 1'b1, 1'b0);
      offer_bad("t3_ref0", 4'd0, 8'($urandom_range(1, 255)), 1'b1, 1'b0);

      // Short glitch is filtered
      pll_locked_i = 1'b0;
      repeat (LOL - 1) step();
      pll_locked_i = 1'b1;
      bad = 0;
      repeat (8) begin
         step();
         if (ready_o !== 1'b1 || lock_lost_o !== 1'b0) bad++;
      end
      chk("t4_glitch_ignored", bad, 0);
      $display("glitch of %0d cycles applied", LOL - 1);

      // Loss of lock declared after LOL consecutive unlocked cycles (+2 synchroniser edges)
      pll_locked_i = 1'b0;
      repeat (LOL + 1) step();
      chk("t4_not_yet_lost", lock_lost_o, 0);
      chk("t4_still_ready", ready_o, 1);
      step();
      chk("t4_lost_pulse", lock_lost_o, 1);
      chk("t4_ready_drop", ready_o, 0);
      chk("t4_arst_drop", pll_arst_no, 0);
      measure_reset("t4_relock", 1);
      lock_after("t4_relock", $urandom_range(0, 50));

      // Accept on the same edge as loss-of-lock: accept wins, no pulse
      pll_locked_i = 1'b0;
      repeat (LOL + 1) step();
      accept_cfg("t4_prio", 4'($urandom_range(1, 15)), 8'($urandom_range(1, 255)));
      chk("t4_prio_no_pulse", lock_lost_o, 0);
      measure_reset("t4_prio", 0);
      // Lock raised as late as possible: lock and timeout coincide, lock wins
      lock_after("t4_tie", LAST_LOCK);

      // Lock never comes: timeout (with retries when enabled), then fault
      accept_cfg("t5", 4'($urandom_range(1, 15)), 8'($urandom_range(1, 255)));
      measure_reset("t5", 0);
      for (int a = 0; a < ATTEMPTS; a++) begin
         wait_timeout("t5");
         if (a < ATTEMPTS - 1) measure_reset("t5_retry", 0);
      end
      chk("t5_fault", fault_o, 1);
      chk("t5_fault_arst", pll_arst_no, 0);
      chk("t5_fault_busy", busy_o, 0);
      chk("t5_fault_ready", ready_o, 0);
      chk("t5_fault_cfg_ready", cfg_ready_o, 1);
      repeat (5) step();
      chk("t5_fault_hold", fault_o, 1);
      offer_bad("t5_bad", 4'd0, 8'd0, 1'b0, 1'b1);
      accept_cfg("t5_recover", 4'($urandom_range(1, 15)), 8'($urandom_range(1, 255)));
      measure_reset("t6", 0);

      // Synchronous reset in WAIT_LOCK
      repeat (5) step();
      srst_i = 1'b1;
      step();
      chk("t6_arst", pll_arst_no, 0);
      chk("t6_busy", busy_o, 0);
      chk("t6_fault", fault_o, 0);
      chk("t6_ready", ready_o, 0);
      chk("t6_ref", pll_ref_div_o, 0);
      chk("t6_fb", pll_fb_div_o, 0);
      chk("t6_cfg_ready_in_rst", cfg_ready_o, 0);
      srst_i = 1'b0;
      cur_ref = '0; cur_fb = '0;
      #1;
      chk("t6_cfg_ready_idle", cfg_ready_o, 1);
      $display("srst pulsed in WAIT_LOCK");

      // Random reconfigurations
      step();
      for (int i = 0; i < 4; i++) begin
         accept_cfg("rnd", 4'($urandom_range(1, 15)), 8'($urandom_range(1, 255)));
         measure_reset("rnd", 0);
         lock_after("rnd", $urandom_range(0, LAST_LOCK));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
